// File: rtl/matrixops_seq.sv
// 2x2 matrix multiplier: loads A and B one element pair per enter strobe, computes
// C = A*B with a single multiply-accumulate, then streams C out in row-major order.
module matrixops_seq #(
    parameter int unsigned ELEM_W = 2,
    parameter int unsigned ACC_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enter,
    input  logic [ELEM_W-1:0] X,
    input  logic [ELEM_W-1:0] Y,
    output logic              busy,
    output logic              res_valid,
    output logic [1:0]        res_idx,
    output logic [ACC_W-1:0]  res_data,
    output logic              done,
    output logic              Z
);

    localparam int unsigned PROD_W = 2 * ELEM_W;

    typedef enum logic [1:0] {LOAD, COMP, OUT, DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_k;
    logic [2:0]         r_step;
    logic [ELEM_W-1:0]  r_a [4];
    logic [ELEM_W-1:0]  r_b [4];
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_c [4];

    logic [1:0]         w_i;
    logic [ELEM_W-1:0]  w_a_op;
    logic [ELEM_W-1:0]  w_b_op;
    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W-1:0]   w_sum;
    logic [1:0]         w_next_idx;

    // Even step starts C[i] with A[r][0]*B[0][c]; odd step adds A[r][1]*B[1][c].
    assign w_i        = r_step[2:1];
    assign w_a_op     = r_a[{w_i[1], r_step[0]}];
    assign w_b_op     = r_b[{r_step[0], w_i[0]}];
    assign w_prod     = PROD_W'(w_a_op) * PROD_W'(w_b_op);
    assign w_sum      = (r_step[0] ? r_acc : ACC_W'(0)) + ACC_W'(w_prod);
    assign w_next_idx = res_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= LOAD;
            r_k       <= 2'd0;
            r_step    <= 3'd0;
            r_acc     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_c[i] <= '0;
            end
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= 2'd0;
            res_data  <= '0;
            done      <= 1'b0;
            Z         <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (enter) begin
                        r_a[r_k] <= X;
                        r_b[r_k] <= Y;
                        r_k      <= r_k + 2'd1;
                        if (r_k == 2'd3) begin
                            r_state <= COMP;
                            r_step  <= 3'd0;
                            busy    <= 1'b1;
                        end
                    end
                end
                COMP: begin
                    r_acc  <= w_sum;
                    r_step <= r_step + 3'd1;
                    if (r_step[0]) begin
                        r_c[w_i] <= w_sum;
                    end
                    // C[0] is already final when the last MAC step retires C[3].
                    if (r_step == 3'd7) begin
                        r_state   <= OUT;
                        res_valid <= 1'b1;
                        res_idx   <= 2'd0;
                        res_data  <= r_c[0];
                    end
                end
                OUT: begin
                    if (res_idx == 2'd3) begin
                        r_state   <= DONE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                        res_idx   <= 2'd0;
                        res_data  <= '0;
                        done      <= 1'b1;
                        Z         <= (r_c[1] == r_c[2]);
                    end else begin
                        res_idx  <= w_next_idx;
                        res_data <= r_c[w_next_idx];
                    end
                end
                DONE: begin
                    r_state <= LOAD;
                    r_k     <= 2'd0;
                    done    <= 1'b0;
                end
                default: r_state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_matrixops_seq.sv
// Randomized and directed bench for matrixops_seq against a plain matrix-product model.
module tb_matrixops_seq;

    localparam int unsigned ELEM_W = 2;
    localparam int unsigned ACC_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enter = 1'b0;
    logic [ELEM_W-1:0] X = '0;
    logic [ELEM_W-1:0] Y = '0;
    logic              busy, res_valid, done, Z;
    logic [1:0]        res_idx;
    logic [ACC_W-1:0]  res_data;

    int n_checks = 0;
    int n_fail   = 0;

    int op_a [4];
    int op_b [4];
    int gap  [4];
    int ma   [4];
    int mb   [4];
    int mc   [4];
    bit model_z = 1'b0;

    matrixops_seq #(.ELEM_W(ELEM_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .enter(enter), .X(X), .Y(Y),
        .busy(busy), .res_valid(res_valid), .res_idx(res_idx),
        .res_data(res_data), .done(done), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},      32'(busy),      32'(0));
        chk({tag, ".res_valid"}, 32'(res_valid), 32'(0));
        chk({tag, ".res_idx"},   32'(res_idx),   32'(0));
        chk({tag, ".res_data"},  32'(res_data),  32'(0));
        chk({tag, ".done"},      32'(done),      32'(0));
        chk({tag, ".Z"},         32'(Z),         32'(model_z));
    endtask

    task automatic rand_op();
        for (int k = 0; k < 4; k++) begin
            op_a[k] = int'($urandom_range(3, 0));
            op_b[k] = int'($urandom_range(3, 0));
            gap[k]  = int'($urandom_range(2, 0));
        end
    endtask

    // Enter the four element pairs with the requested idle gaps before each.
    task automatic load_entries();
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap[k]; g++) begin
                enter = 1'b0;
                X = ELEM_W'($urandom);
                Y = ELEM_W'($urandom);
                tick();
            end
            chk("load.busy", 32'(busy), 32'(0));
            enter = 1'b1;
            X = ELEM_W'(op_a[k]);
            Y = ELEM_W'(op_b[k]);
            ma[k] = op_a[k];
            mb[k] = op_b[k];
            tick();
        end
        enter = 1'b0;
    endtask

    // Check cycles 1..13 after the 4th accepted enter; optionally keep enter high with junk data.
    task automatic observe(input bit hold);
        bit newz;
        bit vld;
        for (int i = 0; i < 4; i++)
            mc[i] = ma[(i / 2) * 2] * mb[i % 2] + ma[(i / 2) * 2 + 1] * mb[2 + i % 2];
        newz = (mc[1] == mc[2]);
        for (int n = 1; n <= 13; n++) begin
            vld = (n >= 9 && n <= 12);
            chk("op.busy",      32'(busy),      32'(n <= 12));
            chk("op.res_valid", 32'(res_valid), 32'(vld));
            chk("op.res_idx",   32'(res_idx),   vld ? 32'(n - 9) : 32'(0));
            chk("op.res_data",  32'(res_data),  vld ? 32'(mc[n - 9]) : 32'(0));
            chk("op.done",      32'(done),      32'(n == 13));
            chk("op.Z",         32'(Z),         (n == 13) ? 32'(newz) : 32'(model_z));
            enter = hold;
            X = ELEM_W'($urandom);
            Y = ELEM_W'($urandom);
            tick();
        end
        enter = 1'b0;
        model_z = newz;
    endtask

    task automatic run_op(input bit hold);
        load_entries();
        observe(hold);
    endtask

    // Load, then pulse reset (with a coincident enter) during COMP cycle `cyc`.
    task automatic abort_at(input int cyc);
        load_entries();
        for (int n = 1; n < cyc; n++) begin
            chk("abort.busy", 32'(busy), 32'(1));
            tick();
        end
        rst = 1'b1;
        enter = 1'b1;
        tick();
        model_z = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
        chk_idle("abort.rst");
        rst = 1'b0;
        enter = 1'b0;
        for (int n = 0; n < 16; n++) begin
            chk_idle("abort.after");
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("idle");

        // Identity times [0,1;2,3]
        op_a = '{1, 0, 0, 1};
        op_b = '{0, 1, 2, 3};
        gap  = '{0, 0, 0, 0};
        run_op(1'b0);

        // All threes, then an asymmetric result: Z must stay 1 until the second DONE
        op_a = '{3, 3, 3, 3};
        op_b = '{3, 3, 3, 3};
        run_op(1'b0);
        op_a = '{1, 0, 0, 1};
        op_b = '{0, 1, 2, 3};
        run_op(1'b0);

        // Gapped entry of a symmetric A times identity
        op_a = '{1, 2, 2, 1};
        op_b = '{1, 0, 0, 1};
        gap  = '{0, 1, 2, 1};
        run_op(1'b0);

        // Enter held through COMP/OUT/DONE, then an immediate new load at cycle 14
        rand_op();
        gap = '{0, 0, 0, 0};
        run_op(1'b1);
        rand_op();
        gap = '{0, 0, 0, 0};
        run_op(1'b0);

        // Reset during COMP, then a fresh load
        rand_op();
        abort_at(5);
        rand_op();
        run_op(1'b0);

        // Reset mid-LOAD with a coincident enter that must be discarded
        enter = 1'b1;
        X = 2'd3;
        Y = 2'd3;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enter = 1'b0;
        model_z = 1'b0;
        chk_idle("midload.rst");
        op_a = '{2, 1, 0, 3};
        op_b = '{1, 2, 3, 0};
        gap  = '{1, 0, 0, 0};
        run_op(1'b0);

        for (int t = 0; t < 12; t++) begin
            rand_op();
            run_op(1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrixops_seq.md
MATRIXOPS_SEQ -- requirements
Module: matrixops_seq

Interface
REQ-001 Parameter: ELEM_W, default 2, width of each entered matrix element (X, Y).
REQ-002 Parameter: ACC_W, default 5, width of each product-matrix element, sized so that 2*(2^ELEM_W-1)^2 fits (18 for ELEM_W=2).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port: clk, input, 1, rising-edge clock for all state.
REQ-005 Port: rst, input, 1, synchronous active-high reset.
REQ-006 Port: enter, input, 1, element-entry strobe, sampled at rising edge.
REQ-007 Port: X, input, ELEM_W, element of matrix A, captured with enter.
REQ-008 Port: Y, input, ELEM_W, element of matrix B, captured with enter.
REQ-009 Port: busy, output, 1, high while in COMP or OUT.
REQ-010 Port: res_valid, output, 1, high for exactly one cycle per emitted C element.
REQ-011 Port: res_idx, output, 2, row-major index of emitted C element (0=C00, 1=C01, 2=C10, 3=C11).
REQ-012 Port: res_data, output, ACC_W, value of emitted C element.
REQ-013 Port: done, output, 1, one-cycle pulse on completion.
REQ-014 Port: Z, output, 1, symmetry flag of last result (1 iff C01==C10).

Function
REQ-015 The FSM SHALL have four states: LOAD, COMP, OUT, DONE.
REQ-016 In LOAD, each cycle with enter=1 SHALL store X into A[k] and Y into B[k] (k=0..3, row-major), then increment k; enter=0 SHALL hold k and storage.
REQ-017 The cycle the 4th element (k=3) is accepted is cycle 0; state SHALL be COMP from cycle 1.
REQ-018 COMP SHALL use a single multiply-accumulate, 8 cycles (1..8), two per C element in index order: cycle 2i+1 acc = A[r][0]*B[0][c]; cycle 2i+2 acc += A[r][1]*B[1][c], C[i] = result (r=i/2, c=i%2).
REQ-019 Arithmetic SHALL be unsigned; products are 2*ELEM_W bits zero-extended to ACC_W; no overflow is possible with default parameters.
REQ-020 OUT SHALL occupy cycles 9..12: res_valid=1, res_idx=0,1,2,3, res_data=C[res_idx].
REQ-021 DONE SHALL occupy cycle 13: done=1, Z updated to (C01==C10); next state LOAD with k=0.
REQ-022 Z SHALL hold its value from DONE until the next DONE or reset.
REQ-023 busy SHALL be 1 in cycles 1..12 and 0 in LOAD and DONE.
REQ-024 enter, X, Y SHALL be ignored outside LOAD; entries during COMP/OUT/DONE are not stored and do not advance k.
REQ-025 res_valid, res_idx, res_data SHALL be 0 whenever not in OUT.
REQ-026 A and B contents SHALL persist after DONE and be overwritten element by element in the next LOAD.

Reset
REQ-027 rst=1 at a rising edge SHALL force state LOAD, k=0, acc=0, C=0, A=0, B=0.
REQ-028 While in reset, all outputs (busy, res_valid, res_idx, res_data, done, Z) SHALL be 0.
REQ-029 rst SHALL take priority over enter in the same cycle; an enter coincident with rst is discarded.
REQ-030 rst asserted in any state (mid-LOAD, COMP, OUT) SHALL abort the operation with no further res_valid or done.

Verification
REQ-031 A=[1,0;0,1], B=[0,1;2,3] entered on 4 consecutive cycles -> res_data 0,1,2,3 on cycles 9..12, done on cycle 13, Z=0.
REQ-032 A=B=all 3 -> res_data 18,18,18,18, Z=1.
REQ-033 A=[1,2;2,1], B=identity, with enter=0 gaps of 1 and 2 cycles between entries -> timing counted from 4th accepted enter, res_data 1,2,2,1, Z=1.
REQ-034 enter=1 held continuously with varying X,Y through COMP/OUT -> results unchanged from the 4 LOAD entries; next load starts at cycle 14 only.
REQ-035 rst pulsed during cycle 5 of COMP -> no res_valid, no done, all outputs 0; a fresh 4-entry load then completes normally.
REQ-036 Two back-to-back operations (second giving C01!=C10 after first gave Z=1) -> Z stays 1 until second DONE, then 0.
